conv_mac: RTL and testbench
===========================

CONV_MAC -- requirements
Module: conv_mac

Interface
REQ-001 Parameter PIXEL_W, default 8: unsigned pixel width, equal to conv_pkg::PIXEL_W.
REQ-002 Parameter COEF_W, default 8: signed two's-complement coefficient width.
REQ-003 Parameter POS_W, default $bits(conv_pkg::kernel_pos_t): width of the position sideband.
REQ-004 Localparam N = conv_pkg::KERNEL_DIAMETER_N = 5; ACC_W = PIXEL_W+COEF_W+6 = 22.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 kernel_vld_i  input  1  window valid this cycle.
REQ-008 kernel_dat_i  input  N*N*PIXEL_W  conv_pkg::kernel_t; element [m][k] is row m, column k, with k=0 the newest column.
REQ-009 kernel_pos_i  input  POS_W  window position sideband.
REQ-010 cfg_we_i  input  1  shadow coefficient write strobe.
REQ-011 cfg_addr_i  input  5  coefficient index, m*N+k.
REQ-012 cfg_dat_i  input  COEF_W  coefficient value.
REQ-013 cfg_shift_i  input  4  shadow output right-shift amount, sampled on commit.
REQ-014 cfg_commit_i  input  1  request copy of the shadow bank to the active bank.
REQ-015 cfg_busy_o  output  1  commit pending.
REQ-016 pix_vld_o  output  1  result valid.
REQ-017 pix_dat_o  output  PIXEL_W  filtered pixel.
REQ-018 pix_pos_o  output  POS_W  position aligned with pix_dat_o.

Function
REQ-019 The block has no backpressure and SHALL accept a window on every cycle in which kernel_vld_i=1.
REQ-020 Stage S1 SHALL register the 25 products of the zero-extended pixel [m][k] and the active coefficient at index m*N+k, each signed and PIXEL_W+COEF_W+1 bits wide.
REQ-021 Stage S2 SHALL register five row sums, each the sign-extended sum of its five products.
REQ-022 Stage S3 SHALL register the ACC_W-bit signed sum of the five row sums; overflow at ACC_W is impossible by construction.
REQ-023 Stage S4 SHALL compute the output from the S3 sum as follows:
- If shift s>0, add 2^(s-1); then arithmetic right shift by s.
- Saturate the result: values <0 become 0; values >2^PIXEL_W-1 become 2^PIXEL_W-1.
- Register the result to pix_dat_o.
REQ-024 Latency SHALL be exactly 4 cycles: a window accepted in cycle t produces pix_vld_o=1 in cycle t+4.
REQ-025 Valid and pos SHALL travel in a 4-deep pipeline alongside data; data registers SHALL load only when the corresponding stage valid is set.
REQ-026 When pix_vld_o=0, pix_dat_o and pix_pos_o SHALL hold their last values.
REQ-027 cfg_we_i SHALL write cfg_dat_i into the shadow entry cfg_addr_i.
REQ-028 A write with cfg_addr_i>=25 SHALL be ignored.
REQ-029 cfg_commit_i SHALL set the pending flag; cfg_busy_o SHALL equal the pending flag.
REQ-030 Commit state machine, states IDLE and PEND:
- IDLE->PEND on cfg_commit_i.
- PEND->IDLE on the first cycle with kernel_vld_i=0 (this may be the commit cycle itself). On that edge, all 25 active coefficients and the active shift SHALL load from shadow.
REQ-031 While PEND, windows SHALL continue to use the old active bank.
REQ-032 Windows already in S1-S4 at swap SHALL complete with the shift value captured into their S3 stage valid, so the shift SHALL be pipelined with the data.
REQ-033 A write and a commit in the same cycle SHALL include the write in the committed bank.
REQ-034 A write in the same cycle as the swap SHALL land in the shadow bank only, and SHALL become active on the next commit.
REQ-035 cfg_commit_i while already PEND SHALL have no additional effect.

Reset
REQ-036 On arst_n=0 all pipeline valids, pending, pix_vld_o, pix_dat_o, pix_pos_o and cfg_busy_o SHALL clear to 0.
REQ-037 On arst_n=0 both banks SHALL reset to identity: index 12 (centre) = 1, all other indices = 0, shift = 0.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight windows and any pending commit; no pix_vld_o SHALL follow deassertion until new input arrives.

Verification
REQ-039 After reset, window with all pixels 0 except [2][2]=0xA5 -> pix_dat_o=0xA5 four cycles later, pix_pos_o matching the input.
REQ-040 Load all 25 coefficients = 1, shift = 0, commit; all pixels 0xFF -> 6375 saturates to 0xFF. Shift=5, all pixels 0x10 -> (400+16)>>5 = 13.
REQ-041 Centre coefficient = -1, others 0; pixel 0x40 -> output 0 (negative clamp).
REQ-042 Continuous kernel_vld_i=1 for 20 cycles with a commit at cycle 3 -> cfg_busy_o stays 1 and old coefficients are used until the first idle cycle; windows after the gap use the new bank.
REQ-043 Back-to-back windows every cycle, then arst_n pulsed low at cycle 2 -> no pix_vld_o afterwards; the bank returns to identity.
REQ-044 Write to cfg_addr_i=25..31 followed by commit -> output identical to identity behaviour.

Source files
------------

// File: rtl/conv_mac.sv
// 5x5 convolution multiply-accumulate: four-stage pipeline (multiply, row sum, total,
// round/saturate) with a shadow coefficient bank that is swapped in on an idle cycle.

package conv_pkg;
    localparam int PIXEL_W           = 8;
    localparam int KERNEL_DIAMETER_N = 5;

    typedef logic [KERNEL_DIAMETER_N-1:0][KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0] kernel_t;
    typedef logic [15:0] kernel_pos_t;
endpackage

module conv_mac #(
    parameter int PIXEL_W = conv_pkg::PIXEL_W,
    parameter int COEF_W  = 8,
    parameter int POS_W   = $bits(conv_pkg::kernel_pos_t)
) (
    input  logic                                        clk,
    input  logic                                        arst_n,
    input  logic                                        kernel_vld_i,
    input  logic [conv_pkg::KERNEL_DIAMETER_N*conv_pkg::KERNEL_DIAMETER_N*PIXEL_W-1:0] kernel_dat_i,
    input  logic [POS_W-1:0]                            kernel_pos_i,
    input  logic                                        cfg_we_i,
    input  logic [4:0]                                  cfg_addr_i,
    input  logic [COEF_W-1:0]                           cfg_dat_i,
    input  logic [3:0]                                  cfg_shift_i,
    input  logic                                        cfg_commit_i,
    output logic                                        cfg_busy_o,
    output logic                                        pix_vld_o,
    output logic [PIXEL_W-1:0]                          pix_dat_o,
    output logic [POS_W-1:0]                            pix_pos_o
);

    localparam int N      = conv_pkg::KERNEL_DIAMETER_N;
    localparam int NN     = N * N;
    localparam int CENTRE = NN / 2;
    localparam int PROD_W = PIXEL_W + COEF_W + 1;
    localparam int ROW_W  = PROD_W + 3;
    localparam int ACC_W  = PIXEL_W + COEF_W + 6;
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << PIXEL_W) - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t state_reg, state_next;
    logic   swap;
    logic   swap_direct;

    logic signed [COEF_W-1:0] shadow_coef [NN];
    logic signed [COEF_W-1:0] active_coef [NN];
    logic [3:0]               shadow_shift;
    logic [3:0]               active_shift;
    logic [NN-1:0]            wr_hit;

    logic signed [PROD_W-1:0] prod_comb [NN];
    logic signed [PROD_W-1:0] s1_prod   [NN];
    logic signed [ROW_W-1:0]  row_comb  [N];
    logic signed [ROW_W-1:0]  s2_row    [N];
    logic signed [ACC_W-1:0]  acc_comb;
    logic signed [ACC_W-1:0]  s3_acc;

    logic                     s1_vld, s2_vld, s3_vld;
    logic [POS_W-1:0]         s1_pos, s2_pos, s3_pos;
    logic [3:0]               s1_shift, s2_shift, s3_shift;

    logic signed [ACC_W:0]    rnd_add;
    logic signed [ACC_W:0]    rounded;
    logic signed [ACC_W:0]    shifted;
    logic [PIXEL_W-1:0]       pix_dat_next;

    // ---------------------------------------------------------------- commit FSM
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A commit on an idle cycle swaps immediately and never enters PEND.
    always_comb begin
        state_next  = state_reg;
        swap        = 1'b0;
        swap_direct = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg_commit_i) begin
                    if (!kernel_vld_i) begin
                        swap        = 1'b1;
                        swap_direct = 1'b1;
                    end else begin
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                if (!kernel_vld_i) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cfg_busy_o = (state_reg == PEND);

    // ---------------------------------------------------------------- coefficient banks
    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_mul
            logic [PIXEL_W-1:0] pix;
            assign pix           = kernel_dat_i[gi*PIXEL_W +: PIXEL_W];
            assign wr_hit[gi]    = cfg_we_i && (cfg_addr_i == 5'(gi));
            assign prod_comb[gi] = PROD_W'($signed({1'b0, pix})) * PROD_W'(active_coef[gi]);
        end
    endgenerate

    // Addresses 25..31 match no wr_hit bit, so such writes fall away.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NN; i++) begin
                shadow_coef[i] <= (i == CENTRE) ? COEF_W'(1) : '0;
                active_coef[i] <= (i == CENTRE) ? COEF_W'(1) : '0;
            end
            shadow_shift <= '0;
            active_shift <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (wr_hit[i]) begin
                    shadow_coef[i] <= cfg_dat_i;
                end
                // Same-cycle write joins an immediate commit; a write on a deferred swap does not.
                if (swap) begin
                    active_coef[i] <= (swap_direct && wr_hit[i]) ? cfg_dat_i : shadow_coef[i];
                end
            end
            if (cfg_commit_i && state_reg == IDLE) begin
                shadow_shift <= cfg_shift_i;
            end
            if (swap) begin
                active_shift <= swap_direct ? cfg_shift_i : shadow_shift;
            end
        end
    end

    // ---------------------------------------------------------------- adder trees
    always_comb begin
        for (int m = 0; m < N; m++) begin
            row_comb[m] = '0;
            for (int k = 0; k < N; k++) begin
                row_comb[m] = row_comb[m] + ROW_W'(s1_prod[m*N + k]);
            end
        end
    end

    always_comb begin
        acc_comb = '0;
        for (int m = 0; m < N; m++) begin
            acc_comb = acc_comb + ACC_W'(s2_row[m]);
        end
    end

    // ---------------------------------------------------------------- round and saturate
    always_comb begin
        rnd_add = '0;
        if (s3_shift != 4'd0) begin
            rnd_add[s3_shift - 4'd1] = 1'b1;
        end
        rounded = {s3_acc[ACC_W-1], s3_acc} + rnd_add;
        shifted = rounded >>> s3_shift;
        if (shifted[ACC_W]) begin
            pix_dat_next = '0;
        end else if (shifted > PIX_MAX) begin
            pix_dat_next = '1;
        end else begin
            pix_dat_next = shifted[PIXEL_W-1:0];
        end
    end

    // ---------------------------------------------------------------- pipeline registers
    always_ff @(posedge clk) begin
        if (kernel_vld_i) begin
            for (int i = 0; i < NN; i++) begin
                s1_prod[i] <= prod_comb[i];
            end
        end
        if (s1_vld) begin
            for (int m = 0; m < N; m++) begin
                s2_row[m] <= row_comb[m];
            end
        end
        if (s2_vld) begin
            s3_acc <= acc_comb;
        end
    end

    // The shift rides with each window so in-flight results keep their own bank's shift.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            pix_vld_o <= 1'b0;
            s1_pos    <= '0;
            s2_pos    <= '0;
            s3_pos    <= '0;
            pix_pos_o <= '0;
            s1_shift  <= '0;
            s2_shift  <= '0;
            s3_shift  <= '0;
            pix_dat_o <= '0;
        end else begin
            s1_vld    <= kernel_vld_i;
            s2_vld    <= s1_vld;
            s3_vld    <= s2_vld;
            pix_vld_o <= s3_vld;
            if (kernel_vld_i) begin
                s1_pos   <= kernel_pos_i;
                s1_shift <= active_shift;
            end
            if (s1_vld) begin
                s2_pos   <= s1_pos;
                s2_shift <= s1_shift;
            end
            if (s2_vld) begin
                s3_pos   <= s2_pos;
                s3_shift <= s2_shift;
            end
            if (s3_vld) begin
                pix_pos_o <= s3_pos;
                pix_dat_o <= pix_dat_next;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac: a vector table over several coefficient banks plus
// hand-written sequences for commit timing, reset and ignored configuration writes.

module tb_conv_mac;

    localparam int POS_W = 16;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         kernel_vld;
    logic [199:0] kernel_dat;
    logic [POS_W-1:0] kernel_pos;
    logic         cfg_we;
    logic [4:0]   cfg_addr;
    logic [7:0]   cfg_dat;
    logic [3:0]   cfg_shift;
    logic         cfg_commit;
    logic         cfg_busy;
    logic         pix_vld;
    logic [7:0]   pix_dat;
    logic [POS_W-1:0] pix_pos;

    int n_vec = 0;
    int n_err = 0;

    conv_mac #(.PIXEL_W(8), .COEF_W(8), .POS_W(POS_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .kernel_vld_i (kernel_vld),
        .kernel_dat_i (kernel_dat),
        .kernel_pos_i (kernel_pos),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_dat_i    (cfg_dat),
        .cfg_shift_i  (cfg_shift),
        .cfg_commit_i (cfg_commit),
        .cfg_busy_o   (cfg_busy),
        .pix_vld_o    (pix_vld),
        .pix_dat_o    (pix_dat),
        .pix_pos_o    (pix_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;    // 0 identity, 1 all ones, 2 centre -1
        logic [3:0] shift;
        logic [7:0] fill;
        logic [7:0] centre;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] mk_win(input logic [7:0] fill, input logic [7:0] centre);
        logic [199:0] w;
        for (int i = 0; i < 25; i++) begin
            w[i*8 +: 8] = (i == 12) ? centre : fill;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [7:0] val);
        cfg_we   = 1'b1;
        cfg_addr = 5'(addr);
        cfg_dat  = val;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic commit_now(input logic [3:0] sh);
        cfg_commit = 1'b1;
        cfg_shift  = sh;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic load_shadow(input int kind);
        logic [7:0] c;
        for (int a = 0; a < 25; a++) begin
            case (kind)
                0:       c = (a == 12) ? 8'd1 : 8'd0;
                1:       c = 8'd1;
                default: c = (a == 12) ? 8'hFF : 8'd0;
            endcase
            write_coef(a, c);
        end
    endtask

    task automatic send_window(input string name, input logic [7:0] fill, input logic [7:0] centre,
                               input logic [15:0] pos, input logic [7:0] exp);
        int cnt;
        kernel_vld = 1'b1;
        kernel_dat = mk_win(fill, centre);
        kernel_pos = pos;
        tick();
        kernel_vld = 1'b0;
        cnt = 1;
        while (!pix_vld && cnt < 10) begin
            tick();
            cnt++;
        end
        $display("window %s fill=%02h centre=%02h pos=%04h -> dat=%02h after %0d cycles (want %02h)",
                 name, fill, centre, pos, pix_dat, cnt, exp);
        check({name, "_latency"}, cnt, 4);
        check({name, "_dat"}, pix_dat, exp);
        check({name, "_pos"}, pix_pos, pos);
        tick();
        check({name, "_vld_drop"}, pix_vld, 1'b0);
        check({name, "_hold"}, pix_dat, exp);
    endtask

    task automatic drain();
        repeat (5) tick();
    endtask

    initial begin
        int cur_kind;
        logic [3:0] cur_shift;
        int vld_seen;

        tbl[0]  = '{0, 4'd0, 8'h00, 8'hA5, 8'hA5};
        tbl[1]  = '{0, 4'd0, 8'hFF, 8'h00, 8'h00};
        tbl[2]  = '{0, 4'd0, 8'h12, 8'h7F, 8'h7F};
        tbl[3]  = '{1, 4'd0, 8'hFF, 8'hFF, 8'hFF};  // 6375 saturates
        tbl[4]  = '{1, 4'd0, 8'h01, 8'h01, 8'h19};
        tbl[5]  = '{1, 4'd0, 8'h0A, 8'h00, 8'hF0};
        tbl[6]  = '{1, 4'd0, 8'h0B, 8'h0B, 8'hFF};  // 275
        tbl[7]  = '{1, 4'd5, 8'h10, 8'h10, 8'h0D};  // (400+16)>>5
        tbl[8]  = '{1, 4'd3, 8'h01, 8'h02, 8'h03};  // (26+4)>>3
        tbl[9]  = '{1, 4'd1, 8'h01, 8'h02, 8'h0D};  // (26+1)>>1
        tbl[10] = '{1, 4'd4, 8'h00, 8'h08, 8'h01};  // (8+8)>>4
        tbl[11] = '{1, 4'd4, 8'h00, 8'h07, 8'h00};  // (7+8)>>4
        tbl[12] = '{2, 4'd0, 8'h00, 8'h40, 8'h00};  // -64 clamps
        tbl[13] = '{2, 4'd0, 8'hFF, 8'h00, 8'h00};

        arst_n     = 1'b0;
        kernel_vld = 1'b0;
        kernel_dat = '0;
        kernel_pos = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_dat    = '0;
        cfg_shift  = '0;
        cfg_commit = 1'b0;
        repeat (2) tick();
        arst_n = 1'b1;
        tick();
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_vld", pix_vld, 1'b0);
        check("rst_dat", pix_dat, 8'h00);
        check("rst_pos", pix_pos, 16'h0000);

        cur_kind  = 0;
        cur_shift = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].kind != cur_kind || tbl[i].shift != cur_shift) begin
                load_shadow(tbl[i].kind);
                commit_now(tbl[i].shift);
                cur_kind  = tbl[i].kind;
                cur_shift = tbl[i].shift;
            end
            send_window($sformatf("tbl%0d", i), tbl[i].fill, tbl[i].centre,
                        16'h1000 + 16'(i), tbl[i].exp);
        end

        // Commit during a continuous stream: old bank until the first idle cycle.
        load_shadow(0);
        commit_now(4'd0);
        load_shadow(1);
        for (int i = 0; i < 20; i++) begin
            kernel_vld = 1'b1;
            kernel_dat = mk_win(8'h03, 8'h03);
            kernel_pos = 16'h2000 + 16'(i);
            cfg_commit = (i == 3);
            cfg_shift  = 4'd1;
            tick();
            cfg_commit = 1'b0;
            if (i >= 3) begin
                $display("stream cycle %0d: busy=%0d vld=%0d dat=%02h pos=%04h",
                         i, cfg_busy, pix_vld, pix_dat, pix_pos);
                check("stream_busy", cfg_busy, 1'b1);
                check("stream_vld", pix_vld, 1'b1);
                check("stream_dat", pix_dat, 8'h03);
                check("stream_pos", pix_pos, 16'h2000 + 16'(i - 3));
            end
        end
        kernel_vld = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            $display("stream drain %0d: busy=%0d vld=%0d dat=%02h pos=%04h",
                     j, cfg_busy, pix_vld, pix_dat, pix_pos);
            if (j == 0) check("swap_busy_clear", cfg_busy, 1'b0);
            check("drain_dat", pix_dat, 8'h03);
            check("drain_pos", pix_pos, 16'h2000 + 16'(17 + j));
        end
        tick();
        send_window("new_bank", 8'h03, 8'h03, 16'h2100, 8'h26);  // (75+1)>>1

        // Write and commit together while busy: the write is included.
        kernel_vld = 1'b1;
        kernel_dat = mk_win(8'h00, 8'h00);
        kernel_pos = 16'h3000;
        cfg_we     = 1'b1;
        cfg_addr   = 5'd12;
        cfg_dat    = 8'd5;
        cfg_commit = 1'b1;
        cfg_shift  = 4'd0;
        tick();
        kernel_vld = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        check("wc_busy", cfg_busy, 1'b1);
        tick();
        check("wc_swap", cfg_busy, 1'b0);
        drain();
        send_window("wr_commit", 8'h00, 8'h02, 16'h3001, 8'h0A);

        // Write on the deferred swap cycle stays in shadow until the next commit.
        kernel_vld = 1'b1;
        kernel_pos = 16'h3100;
        cfg_commit = 1'b1;
        cfg_shift  = 4'd0;
        tick();
        kernel_vld = 1'b0;
        cfg_commit = 1'b0;
        write_coef(12, 8'd7);
        drain();
        send_window("wr_at_swap", 8'h00, 8'h02, 16'h3101, 8'h0A);
        commit_now(4'd0);
        send_window("wr_next_commit", 8'h00, 8'h02, 16'h3102, 8'h0E);

        // Second commit while pending must not resample the shift.
        kernel_vld = 1'b1;
        kernel_pos = 16'h3200;
        cfg_commit = 1'b1;
        cfg_shift  = 4'd1;
        tick();
        cfg_shift  = 4'd3;
        tick();
        kernel_vld = 1'b0;
        cfg_commit = 1'b0;
        tick();
        check("dup_commit_idle", cfg_busy, 1'b0);
        drain();
        send_window("dup_commit", 8'h00, 8'h02, 16'h3201, 8'h07);  // (14+1)>>1

        // Reset mid-stream with a commit pending.
        kernel_vld = 1'b1;
        kernel_dat = mk_win(8'h01, 8'h20);
        for (int i = 0; i < 2; i++) begin
            kernel_pos = 16'h4000 + 16'(i);
            cfg_commit = (i == 1);
            tick();
        end
        cfg_commit = 1'b0;
        kernel_vld = 1'b0;
        arst_n     = 1'b0;
        tick();
        arst_n = 1'b1;
        vld_seen = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (pix_vld) vld_seen++;
        end
        $display("after mid-run reset: vld cycles=%0d busy=%0d dat=%02h", vld_seen, cfg_busy, pix_dat);
        check("rst_mid_no_vld", vld_seen, 0);
        check("rst_mid_busy", cfg_busy, 1'b0);
        check("rst_mid_dat", pix_dat, 8'h00);
        check("rst_mid_pos", pix_pos, 16'h0000);
        send_window("rst_identity", 8'h01, 8'h20, 16'h4100, 8'h20);

        // Out-of-range coefficient writes are ignored.
        for (int a = 25; a < 32; a++) begin
            write_coef(a, 8'h7F);
        end
        commit_now(4'd0);
        send_window("oob_a", 8'h01, 8'h20, 16'h5000, 8'h20);
        send_window("oob_b", 8'h00, 8'hC3, 16'h5001, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
